// File: rtl/mem_pkg.sv
// Shared definitions for the memory-access stage.
// Holds the rw request codes from execute, the eight sel access codes,
// the internal access-operation encoding and the transaction FSM states.
package mem_pkg;

    localparam logic [1:0] RW_STORE = 2'b01;
    localparam logic [1:0] RW_LOAD  = 2'b10;
    localparam logic [1:0] RW_NONE  = 2'b11;

    // Store access codes
    localparam logic [3:0] SEL_SB  = 4'b0001;
    localparam logic [3:0] SEL_SH  = 4'b0011;
    localparam logic [3:0] SEL_SW  = 4'b1111;
    // Load access codes (several share bit patterns with store codes)
    localparam logic [3:0] SEL_LB  = 4'b1000;
    localparam logic [3:0] SEL_LH  = 4'b1100;
    localparam logic [3:0] SEL_LW  = 4'b1111;
    localparam logic [3:0] SEL_LBU = 4'b0011;
    localparam logic [3:0] SEL_LHU = 4'b0001;

    typedef enum logic {
        MS_IDLE = 1'b0,
        MS_REQ  = 1'b1
    } ms_state_e;

    // Decoded access, independent of the overlapping sel encodings
    typedef enum logic [2:0] {
        OP_SB, OP_SH, OP_SW, OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW
    } mem_op_e;

endpackage

// File: rtl/mem_stage_load_align.sv
// load_align: combinational lane selection and sign/zero extension of a
// read word.
//   rdata_i  - word returned by the data memory
//   off_i    - byte offset of the access within the word
//   op_i     - decoded load operation (store ops return the word unchanged)
//   result_o - aligned, extended 32-bit load result
module load_align
    import mem_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  off_i,
    input  mem_op_e     op_i,
    output logic [31:0] result_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rdata_i[8*off_i +: 8];
        // Halfword accesses are aligned, so only off[1] picks the lane
        half_sel = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (op_i)
            OP_LB:   result_o = {{24{byte_sel[7]}}, byte_sel};
            OP_LBU:  result_o = {24'd0, byte_sel};
            OP_LH:   result_o = {{16{half_sel[15]}}, half_sel};
            OP_LHU:  result_o = {16'd0, half_sel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access stage between execute and writeback.
// Decodes loads/stores, runs a req/ack transaction on the data-memory bus,
// aligns load data and registers the writeback fields.
//   clk, rst            - clock, asynchronous active-high reset
//   wd_i/wreg_i/wdata_i - writeback fields from execute
//   mem_addr_i, rw_i, sel_i, mem_data_i - memory request from execute
//   dmem_*              - data-memory bus (req/ack handshake)
//   stall_req_o         - holds execute while a transaction is pending
//   wd_o/wreg_o/wdata_o - registered writeback fields
//   bus_err_o           - one-cycle pulse on misalignment or ack timeout
module mem_stage
    import mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic [31:0] wdata_i,
    input  logic [11:0] mem_addr_i,
    input  logic [1:0]  rw_i,
    input  logic [3:0]  sel_i,
    input  logic [31:0] mem_data_i,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [9:0]  dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_req_o,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        bus_err_o
);

    localparam int               CNT_W    = $clog2(ACK_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    ms_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    mem_op_e           op_q, op_d;
    logic [1:0]        off_q, off_d;
    logic              we_q, we_d;
    logic [9:0]        addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       bwdata_q, bwdata_d;
    logic [4:0]        lwd_q, lwd_d;
    logic              lwreg_q, lwreg_d;
    logic [31:0]       lwdata_q, lwdata_d;
    logic [4:0]        wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              err_q, err_d;

    logic [1:0]  off;
    mem_op_e     op_dec;
    logic        is_mem, aligned, go, timeout;
    logic [3:0]  be_dec;
    logic [31:0] bwdata_dec, ld_result;

    assign off = mem_addr_i[1:0];

    // Decode; an unrecognised sel with a load/store rw is not a memory op
    always_comb begin
        op_dec = OP_LW;
        is_mem = 1'b0;
        if (rw_i == RW_STORE) begin
            is_mem = 1'b1;
            case (sel_i)
                SEL_SB:  op_dec = OP_SB;
                SEL_SH:  op_dec = OP_SH;
                SEL_SW:  op_dec = OP_SW;
                default: is_mem = 1'b0;
            endcase
        end else if (rw_i == RW_LOAD) begin
            is_mem = 1'b1;
            case (sel_i)
                SEL_LB:  op_dec = OP_LB;
                SEL_LH:  op_dec = OP_LH;
                SEL_LW:  op_dec = OP_LW;
                SEL_LBU: op_dec = OP_LBU;
                SEL_LHU: op_dec = OP_LHU;
                default: is_mem = 1'b0;
            endcase
        end
    end

    always_comb begin
        aligned    = (off == 2'd0);
        be_dec     = 4'b1111;
        bwdata_dec = mem_data_i;
        case (op_dec)
            OP_LB, OP_LBU: aligned = 1'b1;
            OP_LH, OP_LHU: aligned = ~off[0];
            OP_SB: begin
                aligned    = 1'b1;
                be_dec     = 4'b0001 << off;
                bwdata_dec = {4{mem_data_i[7:0]}};
            end
            OP_SH: begin
                aligned    = ~off[0];
                be_dec     = 4'b0011 << off;
                bwdata_dec = {2{mem_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    assign go      = (state_q == MS_IDLE) & is_mem & aligned;
    assign timeout = (state_q == MS_REQ) & ~dmem_ack & (cnt_q == CNT_LAST);
    assign stall_req_o = go | ((state_q == MS_REQ) & ~dmem_ack & ~timeout);

    load_align u_load_align (
        .rdata_i  (dmem_rdata),
        .off_i    (off_q),
        .op_i     (op_q),
        .result_o (ld_result)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        off_d    = off_q;
        we_d     = we_q;
        addr_d   = addr_q;
        be_d     = be_q;
        bwdata_d = bwdata_q;
        lwd_d    = lwd_q;
        lwreg_d  = lwreg_q;
        lwdata_d = lwdata_q;
        err_d    = 1'b0;
        // Default: pass-through into writeback
        wd_d     = wd_i;
        wreg_d   = wreg_i;
        wdata_d  = wdata_i;
        if (state_q == MS_IDLE) begin
            if (go) begin
                state_d  = MS_REQ;
                cnt_d    = '0;
                op_d     = op_dec;
                off_d    = off;
                we_d     = (op_dec == OP_SB) | (op_dec == OP_SH) | (op_dec == OP_SW);
                addr_d   = mem_addr_i[11:2];
                be_d     = be_dec;
                bwdata_d = bwdata_dec;
                lwd_d    = wd_i;
                lwreg_d  = wreg_i;
                lwdata_d = wdata_i;
                wd_d     = '0;
                wreg_d   = 1'b0;
                wdata_d  = '0;
            end else if (is_mem) begin
                // Misaligned: no bus cycle, kill the register write
                err_d  = 1'b1;
                wreg_d = 1'b0;
            end
        end else begin
            if (dmem_ack) begin
                state_d = MS_IDLE;
                wd_d    = lwd_q;
                wreg_d  = lwreg_q;
                wdata_d = we_q ? lwdata_q : ld_result;
            end else begin
                wd_d    = '0;
                wreg_d  = 1'b0;
                wdata_d = '0;
                if (timeout) begin
                    state_d = MS_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= MS_IDLE;
            cnt_q    <= '0;
            op_q     <= OP_LW;
            off_q    <= '0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            be_q     <= '0;
            bwdata_q <= '0;
            lwd_q    <= '0;
            lwreg_q  <= 1'b0;
            lwdata_q <= '0;
            wd_q     <= '0;
            wreg_q   <= 1'b0;
            wdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            off_q    <= off_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            be_q     <= be_d;
            bwdata_q <= bwdata_d;
            lwd_q    <= lwd_d;
            lwreg_q  <= lwreg_d;
            lwdata_q <= lwdata_d;
            wd_q     <= wd_d;
            wreg_q   <= wreg_d;
            wdata_q  <= wdata_d;
            err_q    <= err_d;
        end
    end

    assign dmem_req   = (state_q == MS_REQ);
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_be    = be_q;
    assign dmem_wdata = bwdata_q;
    assign wd_o       = wd_q;
    assign wreg_o     = wreg_q;
    assign wdata_o    = wdata_q;
    assign bus_err_o  = err_q;

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0;
    logic [31:0] wdata_i = '0;
    logic [11:0] mem_addr_i = '0;
    logic [1:0]  rw_i = 2'b00;
    logic [3:0]  sel_i = '0;
    logic [31:0] mem_data_i = '0;
    logic        dmem_req, dmem_we;
    logic [9:0]  dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_req_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        bus_err_o;

    int n_checks = 0;
    int n_fail   = 0;

    mem_stage #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
        .mem_addr_i(mem_addr_i), .rw_i(rw_i), .sel_i(sel_i), .mem_data_i(mem_data_i),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_req_o(stall_req_o),
        .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .bus_err_o(bus_err_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  rw;
        logic [3:0]  sel;
        logic [11:0] addr;
        logic [31:0] mdata;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        int          delay;   // REQ cycles without ack before the ack cycle
        logic [31:0] rdata;
        logic        e_mem;
        logic        e_we;
        logic [3:0]  e_be;
        logic [31:0] e_bwd;
        logic [4:0]  e_wd;
        logic        e_wreg;
        logic [31:0] e_wdata;
        logic        e_err;
        logic        e_chk;   // compare wd_o/wdata_o
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        rw_i = 2'b00; sel_i = '0; mem_addr_i = '0; mem_data_i = '0;
        wd_i = '0; wreg_i = 1'b0; wdata_i = '0;
    endtask

    function automatic vec_t mk(logic [1:0] rw, logic [3:0] sel, logic [11:0] addr,
                                logic [31:0] mdata, logic [4:0] wd, logic wreg,
                                logic [31:0] wdata, int delay, logic [31:0] rdata,
                                logic e_mem, logic e_we, logic [3:0] e_be, logic [31:0] e_bwd,
                                logic [4:0] e_wd, logic e_wreg, logic [31:0] e_wdata,
                                logic e_err, logic e_chk);
        vec_t v;
        v.rw = rw; v.sel = sel; v.addr = addr; v.mdata = mdata; v.wd = wd; v.wreg = wreg;
        v.wdata = wdata; v.delay = delay; v.rdata = rdata; v.e_mem = e_mem; v.e_we = e_we;
        v.e_be = e_be; v.e_bwd = e_bwd; v.e_wd = e_wd; v.e_wreg = e_wreg; v.e_wdata = e_wdata;
        v.e_err = e_err; v.e_chk = e_chk;
        return v;
    endfunction

    // Reference model: derives expected results from access size, offset
    // and signedness using plain arithmetic.
    function automatic vec_t model(input vec_t v);
        vec_t e = v;
        int size = 4;
        bit sgn = 0, mem = 0;
        int off;
        logic [31:0] mask, val;
        if (v.rw == 2'b01) begin
            case (v.sel)
                4'h1: begin mem = 1; size = 1; end
                4'h3: begin mem = 1; size = 2; end
                4'hF: begin mem = 1; size = 4; end
                default: ;
            endcase
        end else if (v.rw == 2'b10) begin
            case (v.sel)
                4'h8: begin mem = 1; size = 1; sgn = 1; end
                4'hC: begin mem = 1; size = 2; sgn = 1; end
                4'hF: begin mem = 1; size = 4; end
                4'h3: begin mem = 1; size = 1; end
                4'h1: begin mem = 1; size = 2; end
                default: ;
            endcase
        end
        off = int'(v.addr) % 4;
        e.e_mem = 0; e.e_err = 0; e.e_chk = 1; e.e_we = 0; e.e_be = 4'hF; e.e_bwd = v.mdata;
        e.e_wd = v.wd; e.e_wreg = v.wreg; e.e_wdata = v.wdata;
        if (mem && (int'(v.addr) % size) != 0) begin
            e.e_err = 1; e.e_wreg = 0; e.e_chk = 0;
        end else if (mem) begin
            e.e_mem = 1;
            if (v.rw == 2'b01) begin
                e.e_we = 1;
                e.e_be = 4'(((1 << size) - 1) << off);
                if (size == 1)      e.e_bwd = (v.mdata & 32'hFF) * 32'h0101_0101;
                else if (size == 2) e.e_bwd = (v.mdata & 32'hFFFF) * 32'h0001_0001;
                else                e.e_bwd = v.mdata;
            end else begin
                mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 32'd1);
                val  = (v.rdata >> (8 * off)) & mask;
                if (sgn && val[8*size-1]) val = val | ~mask;
                e.e_wdata = val;
            end
        end
        return e;
    endfunction

    task automatic run_op(input vec_t v, input string tag);
        rw_i = v.rw; sel_i = v.sel; mem_addr_i = v.addr; mem_data_i = v.mdata;
        wd_i = v.wd; wreg_i = v.wreg; wdata_i = v.wdata; dmem_ack = 1'b0;
        #1;
        chk({tag, ".stall_c0"}, 32'(stall_req_o), 32'(v.e_mem));
        chk({tag, ".req_c0"}, 32'(dmem_req), 32'd0);
        step();
        if (v.e_mem) begin
            chk({tag, ".req_c1"}, 32'(dmem_req), 32'd1);
            chk({tag, ".we"}, 32'(dmem_we), 32'(v.e_we));
            chk({tag, ".addr"}, 32'(dmem_addr), 32'(v.addr >> 2));
            chk({tag, ".be"}, 32'(dmem_be), 32'(v.e_be));
            if (v.e_we) chk({tag, ".bwdata"}, dmem_wdata, v.e_bwd);
            for (int i = 0; i < v.delay; i++) begin
                chk({tag, ".stall_wait"}, 32'(stall_req_o), 32'd1);
                chk({tag, ".req_wait"}, 32'(dmem_req), 32'd1);
                step();
            end
            dmem_ack = 1'b1; dmem_rdata = v.rdata;
            #1;
            chk({tag, ".stall_ack"}, 32'(stall_req_o), 32'd0);
            @(posedge clk);
            #1;
            dmem_ack = 1'b0; dmem_rdata = '0;
        end
        drive_idle();
        #1;
        chk({tag, ".wreg_o"}, 32'(wreg_o), 32'(v.e_wreg));
        if (v.e_chk) begin
            chk({tag, ".wd_o"}, 32'(wd_o), 32'(v.e_wd));
            chk({tag, ".wdata_o"}, wdata_o, v.e_wdata);
        end
        chk({tag, ".err"}, 32'(bus_err_o), 32'(v.e_err));
        chk({tag, ".req_after"}, 32'(dmem_req), 32'd0);
        chk({tag, ".stall_after"}, 32'(stall_req_o), 32'd0);
        step();
        chk({tag, ".err_gone"}, 32'(bus_err_o), 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mk(2'b11, 4'hF, 12'h000, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 32'h0,
                     0, 0, 4'hF, 32'h0, 5'd5, 1'b1, 32'h1234, 0, 1);
        tbl[1]  = mk(2'b10, 4'h8, 12'h013, 32'h0, 5'd3, 1'b1, 32'hDEAD, 0, 32'h80FF_0000,
                     1, 0, 4'hF, 32'h0, 5'd3, 1'b1, 32'hFFFF_FF80, 0, 1);
        tbl[2]  = mk(2'b10, 4'h3, 12'h013, 32'h0, 5'd3, 1'b1, 32'hDEAD, 0, 32'h80FF_0000,
                     1, 0, 4'hF, 32'h0, 5'd3, 1'b1, 32'h0000_0080, 0, 1);
        tbl[3]  = mk(2'b01, 4'h3, 12'h006, 32'hABCD_5678, 5'd7, 1'b0, 32'h55, 2, 32'h0,
                     1, 1, 4'hC, 32'h5678_5678, 5'd7, 1'b0, 32'h55, 0, 1);
        tbl[4]  = mk(2'b10, 4'hF, 12'h002, 32'h0, 5'd4, 1'b1, 32'h1, 0, 32'h0,
                     0, 0, 4'hF, 32'h0, 5'd4, 1'b0, 32'h1, 1, 0);
        tbl[5]  = mk(2'b10, 4'hC, 12'h00A, 32'h0, 5'd8, 1'b1, 32'h0, 1, 32'h8001_7FFF,
                     1, 0, 4'hF, 32'h0, 5'd8, 1'b1, 32'hFFFF_8001, 0, 1);
        tbl[6]  = mk(2'b10, 4'h1, 12'h008, 32'h0, 5'd9, 1'b1, 32'h0, 0, 32'h1234_F00D,
                     1, 0, 4'hF, 32'h0, 5'd9, 1'b1, 32'h0000_F00D, 0, 1);
        tbl[7]  = mk(2'b01, 4'h1, 12'h001, 32'h0000_00A5, 5'd2, 1'b1, 32'h99, 0, 32'h0,
                     1, 1, 4'h2, 32'hA5A5_A5A5, 5'd2, 1'b1, 32'h99, 0, 1);
        tbl[8]  = mk(2'b01, 4'hF, 12'h010, 32'hCAFE_BABE, 5'd1, 1'b1, 32'h42, 1, 32'h0,
                     1, 1, 4'hF, 32'hCAFE_BABE, 5'd1, 1'b1, 32'h42, 0, 1);
        tbl[9]  = mk(2'b10, 4'hF, 12'h100, 32'h0, 5'd10, 1'b1, 32'h0, 0, 32'h1122_3344,
                     1, 0, 4'hF, 32'h0, 5'd10, 1'b1, 32'h1122_3344, 0, 1);
        tbl[10] = mk(2'b10, 4'h5, 12'h003, 32'h0, 5'd9, 1'b1, 32'h777, 0, 32'h0,
                     0, 0, 4'hF, 32'h0, 5'd9, 1'b1, 32'h777, 0, 1);
        tbl[11] = mk(2'b01, 4'h3, 12'h003, 32'h1111, 5'd6, 1'b1, 32'h5, 0, 32'h0,
                     0, 0, 4'hF, 32'h0, 5'd6, 1'b0, 32'h5, 1, 0);
        tbl[12] = mk(2'b10, 4'h8, 12'h000, 32'h0, 5'd11, 1'b1, 32'h0, 0, 32'h0000_007F,
                     1, 0, 4'hF, 32'h0, 5'd11, 1'b1, 32'h0000_007F, 0, 1);
        // Ack on the terminal count counts as success
        tbl[13] = mk(2'b10, 4'hF, 12'h030, 32'h0, 5'd6, 1'b1, 32'h0, 15, 32'h0BAD_F00D,
                     1, 0, 4'hF, 32'h0, 5'd6, 1'b1, 32'h0BAD_F00D, 0, 1);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.req", 32'(dmem_req), 32'd0);
        chk("rst.be", 32'(dmem_be), 32'd0);
        chk("rst.wreg", 32'(wreg_o), 32'd0);
        chk("rst.wdata", wdata_o, 32'd0);
        chk("rst.err", 32'(bus_err_o), 32'd0);
        rst = 1'b0;
        step();

        foreach (tbl[i]) run_op(tbl[i], $sformatf("vec%0d", i));

        // Timeout: no ack for ACK_TIMEOUT cycles
        rw_i = 2'b10; sel_i = 4'hF; mem_addr_i = 12'h020; wd_i = 5'd4; wreg_i = 1'b1; wdata_i = 32'h77;
        step();
        for (int i = 0; i < 16; i++) begin
            chk("to.req", 32'(dmem_req), 32'd1);
            chk("to.stall", 32'(stall_req_o), (i == 15) ? 32'd0 : 32'd1);
            step();
        end
        drive_idle();
        #1;
        chk("to.req_drop", 32'(dmem_req), 32'd0);
        chk("to.err", 32'(bus_err_o), 32'd1);
        chk("to.wreg", 32'(wreg_o), 32'd0);
        step();
        chk("to.err_gone", 32'(bus_err_o), 32'd0);

        // Back-to-back: second op presented right after the ack edge
        rw_i = 2'b10; sel_i = 4'hF; mem_addr_i = 12'h004; wd_i = 5'd12; wreg_i = 1'b1;
        step();
        dmem_ack = 1'b1; dmem_rdata = 32'hAAAA_0001;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        mem_addr_i = 12'h008; wd_i = 5'd13;
        #1;
        chk("b2b.stall_c0", 32'(stall_req_o), 32'd1);
        chk("b2b.req_idle", 32'(dmem_req), 32'd0);
        chk("b2b.first", wdata_o, 32'hAAAA_0001);
        step();
        chk("b2b.req2", 32'(dmem_req), 32'd1);
        chk("b2b.addr2", 32'(dmem_addr), 32'd2);
        dmem_ack = 1'b1; dmem_rdata = 32'hBBBB_0002;
        @(posedge clk);
        #1;
        dmem_ack = 1'b0;
        drive_idle();
        #1;
        chk("b2b.second", wdata_o, 32'hBBBB_0002);
        chk("b2b.wd2", 32'(wd_o), 32'd13);
        step();

        // Reset in REQ: outputs clear without a clock edge, late ack ignored
        rw_i = 2'b01; sel_i = 4'hF; mem_addr_i = 12'h0F0; mem_data_i = 32'h1357; wreg_i = 1'b1;
        step();
        chk("rreq.req", 32'(dmem_req), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("rreq.req0", 32'(dmem_req), 32'd0);
        chk("rreq.addr0", 32'(dmem_addr), 32'd0);
        chk("rreq.be0", 32'(dmem_be), 32'd0);
        chk("rreq.we0", 32'(dmem_we), 32'd0);
        drive_idle();
        step();
        rst = 1'b0;
        dmem_ack = 1'b1; dmem_rdata = 32'hFFFF_FFFF;
        #1;
        chk("rreq.stall", 32'(stall_req_o), 32'd0);
        step();
        dmem_ack = 1'b0;
        chk("rreq.wreg", 32'(wreg_o), 32'd0);
        chk("rreq.wdata", wdata_o, 32'd0);
        chk("rreq.req_late", 32'(dmem_req), 32'd0);

        // Randomized ops against the reference model
        for (int n = 0; n < 40; n++) begin
            vec_t v;
            logic [3:0] pool [6];
            pool[0] = 4'h1; pool[1] = 4'h3; pool[2] = 4'hF; pool[3] = 4'h8; pool[4] = 4'hC;
            pool[5] = 4'($urandom);
            v = mk(2'($urandom), pool[$urandom_range(0, 5)], 12'($urandom), $urandom,
                   5'($urandom), 1'($urandom), $urandom, $urandom_range(0, 4), $urandom,
                   0, 0, 0, 0, 0, 0, 0, 0, 0);
            run_op(model(v), $sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
